// File: rtl/alias_group_resolver.sv
// Shared-net resolver: round-robin locked ownership, registered net, conflict flag/count.
// Define ALIAS_RESOLVER_WAND_EN for wired-AND resolution instead of ownership.
module alias_group_resolver #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       N_CH      = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       drv_en,
  input  logic [N_CH*WIDTH-1:0] drv_data,
  output logic [WIDTH-1:0]      net_q,
  output logic                  owner_vld,
  output logic [N_CH-1:0]       owner_oh,
  output logic                  conflict,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [WIDTH-1:0] r_net;
  logic [N_CH-1:0]  r_oh;
  logic             r_conflict;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;

  // Any enabled driver differing from the first enabled one is a disagreement
  always_comb begin
    logic [WIDTH-1:0] v_ref;
    logic             v_have;
    v_ref  = '0;
    v_have = 1'b0;
    w_diff = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (drv_en[i]) begin
        if (!v_have) begin
          v_ref  = drv_data[i*WIDTH +: WIDTH];
          v_have = 1'b1;
        end else if (drv_data[i*WIDTH +: WIDTH] != v_ref) begin
          w_diff = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_conflict <= w_diff;
      if (w_diff && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef ALIAS_RESOLVER_WAND_EN

  logic [WIDTH-1:0] w_and;
  logic             r_vld;

  always_comb begin
    w_and = '1;
    for (int i = 0; i < N_CH; i++) begin
      if (drv_en[i])
        w_and = w_and & drv_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_net <= RESET_VAL;
      r_oh  <= '0;
      r_vld <= 1'b0;
    end else begin
      if (|drv_en)
        r_net <= w_and;
      r_oh  <= drv_en;
      r_vld <= |drv_en;
    end
  end

  assign owner_vld = r_vld;

`else

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    w_owner_nxt;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    w_ptr_nxt;
  logic [IW-1:0]    w_rel_ptr;
  logic [N_CH-1:0]  w_oh_nxt;
  logic [WIDTH-1:0] w_net_nxt;
  logic             w_req_any;

  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] idx);
    return (idx == IW'(N_CH-1)) ? '0 : idx + 1'b1;
  endfunction

  // First requester at or after ptr, wrapping at N_CH-1
  function automatic logic [IW-1:0] f_pick(
    input logic [N_CH-1:0] req,
    input logic [IW-1:0]   ptr
  );
    logic          found;
    logic [IW-1:0] cur;
    logic [IW-1:0] sel;
    found = 1'b0;
    cur   = ptr;
    sel   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && req[cur]) begin
        found = 1'b1;
        sel   = cur;
      end
      cur = f_inc(cur);
    end
    return sel;
  endfunction

  function automatic logic [N_CH-1:0] f_oh(input logic [IW-1:0] idx);
    logic [N_CH-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (IW'(i) == idx)
        oh[i] = 1'b1;
    end
    return oh;
  endfunction

  function automatic logic [WIDTH-1:0] f_data(
    input logic [N_CH*WIDTH-1:0] data,
    input logic [IW-1:0]         idx
  );
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (IW'(i) == idx)
        v = data[i*WIDTH +: WIDTH];
    end
    return v;
  endfunction

  assign w_req_any = |drv_en;
  assign w_rel_ptr = f_inc(r_owner);

  always_comb begin
    logic [IW-1:0] v_g;
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_oh_nxt    = r_oh;
    w_net_nxt   = r_net;
    v_g         = '0;
    unique case (r_state)
      IDLE: begin
        if (w_req_any) begin
          v_g         = f_pick(drv_en, r_ptr);
          w_state_nxt = OWNED;
          w_owner_nxt = v_g;
          w_oh_nxt    = f_oh(v_g);
          w_net_nxt   = f_data(drv_data, v_g);
        end
      end
      OWNED: begin
        if (drv_en[r_owner]) begin
          w_net_nxt = f_data(drv_data, r_owner);
        end else begin
          w_ptr_nxt = w_rel_ptr;
          // Hand off on the release edge, no idle bubble
          if (w_req_any) begin
            v_g         = f_pick(drv_en, w_rel_ptr);
            w_owner_nxt = v_g;
            w_oh_nxt    = f_oh(v_g);
            w_net_nxt   = f_data(drv_data, v_g);
          end else begin
            w_state_nxt = IDLE;
            w_oh_nxt    = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_oh_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_oh    <= '0;
      r_net   <= RESET_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_oh    <= w_oh_nxt;
      r_net   <= w_net_nxt;
    end
  end

  assign owner_vld = (r_state == OWNED);

`endif

  assign net_q        = r_net;
  assign owner_oh     = r_oh;
  assign conflict     = r_conflict;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_alias_group_resolver.sv
// Scoreboard bench for alias_group_resolver (N_CH=3, WIDTH=32, CNT_W=8).
module tb_alias_group_resolver;

  logic        clk;
  logic        rst_n;
  logic [2:0]  drv_en;
  logic [95:0] drv_data;
  logic [31:0] net_q;
  logic        owner_vld;
  logic [2:0]  owner_oh;
  logic        conflict;
  logic [7:0]  conflict_cnt;

  typedef struct {
    logic [31:0] net;
    logic [2:0]  oh;
    logic        vld;
    logic        conf;
    logic [7:0]  cnt;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  alias_group_resolver #(
    .WIDTH(32), .N_CH(3), .RESET_VAL(32'h0), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .drv_en(drv_en), .drv_data(drv_data),
    .net_q(net_q), .owner_vld(owner_vld), .owner_oh(owner_oh),
    .conflict(conflict), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.tag, ".net_q"},        net_q,               e.net);
    chk({e.tag, ".owner_oh"},     {29'd0, owner_oh},   {29'd0, e.oh});
    chk({e.tag, ".owner_vld"},    {31'd0, owner_vld},  {31'd0, e.vld});
    chk({e.tag, ".conflict"},     {31'd0, conflict},   {31'd0, e.conf});
    chk({e.tag, ".conflict_cnt"}, {24'd0, conflict_cnt}, {24'd0, e.cnt});
  endtask

  // Monitor: every clock edge with a pending expectation is checked
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) chk_all(q.pop_front());
  end

  task automatic step(
    input string tag, input logic [2:0] en,
    input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
    input logic [31:0] enet, input logic [2:0] eoh, input logic evld,
    input logic econf, input logic [7:0] ecnt
  );
    exp_t e;
    drv_en   = en;
    drv_data = {d2, d1, d0};
    e.net = enet; e.oh = eoh; e.vld = evld;
    e.conf = econf; e.cnt = ecnt; e.tag = tag;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t r0;
    logic [7:0] ecnt;
    rst_n    = 1'b0;
    drv_en   = '0;
    drv_data = '0;
    r0.net = 32'h0; r0.oh = 3'b000; r0.vld = 1'b0;
    r0.conf = 1'b0; r0.cnt = 8'd0; r0.tag = "in_reset";
    @(negedge clk);
    do_reset();
    chk_all(r0);
    for (int i = 0; i < 5; i++)
      step("idle", 3'b000, 0, 0, 0, 32'h0, 3'b000, 0, 0, 8'd0);

`ifdef ALIAS_RESOLVER_WAND_EN
    step("wand2", 3'b011, 32'hf0f0ffff, 32'hffff0f0f, 32'h0,
         32'hf0f00f0f, 3'b011, 1, 1, 8'd1);
    step("wand_none", 3'b000, 32'h1, 32'h2, 32'h3,
         32'hf0f00f0f, 3'b000, 0, 0, 8'd1);
    step("wand_one", 3'b100, 32'h0, 32'h0, 32'h12345678,
         32'h12345678, 3'b100, 1, 0, 8'd1);
    step("wand_eq", 3'b101, 32'h0000ff00, 32'h0, 32'h0000ff00,
         32'h0000ff00, 3'b101, 1, 0, 8'd1);
`else
    step("grant0", 3'b001, 32'hdeadbeef, 0, 0,
         32'hdeadbeef, 3'b001, 1, 0, 8'd0);
    step("hold0", 3'b001, 32'hdeadbeef, 0, 0,
         32'hdeadbeef, 3'b001, 1, 0, 8'd0);
    step("lock_eq", 3'b111, 32'hdeadbeef, 32'hdeadbeef, 32'hdeadbeef,
         32'hdeadbeef, 3'b001, 1, 0, 8'd0);
    step("release", 3'b000, 32'h0, 32'h0, 32'h0,
         32'hdeadbeef, 3'b000, 0, 0, 8'd0);
    step("rr_ch1", 3'b110, 32'h0, 32'h1, 32'h2,
         32'h1, 3'b010, 1, 1, 8'd1);
    step("handoff", 3'b100, 32'h0, 32'h0, 32'h2,
         32'h2, 3'b100, 1, 0, 8'd1);
    step("track2", 3'b100, 32'h0, 32'h0, 32'h3,
         32'h3, 3'b100, 1, 0, 8'd1);
    step("wrap_ho", 3'b011, 32'h5, 32'h6, 32'h0,
         32'h5, 3'b001, 1, 1, 8'd2);
    ecnt = 8'd2;
    for (int k = 1; k < 300; k++) begin
      ecnt = (ecnt == 8'd255) ? 8'd255 : ecnt + 8'd1;
      step("sat", 3'b011, 32'h5, 32'h6, 32'h0,
           32'h5, 3'b001, 1, 1, ecnt);
    end
    step("sat_end", 3'b000, 32'h0, 32'h0, 32'h0,
         32'h5, 3'b000, 0, 0, 8'd255);
    step("wrap_idle", 3'b001, 32'h7, 32'h0, 32'h0,
         32'h7, 3'b001, 1, 0, 8'd255);
    step("eq_multi", 3'b101, 32'h7, 32'h0, 32'h7,
         32'h7, 3'b001, 1, 0, 8'd255);
    #2;
    rst_n = 1'b0;
    #1;
    r0.tag = "async_rst";
    chk_all(r0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 3'b100, 32'h0, 32'h0, 32'h9,
         32'h9, 3'b100, 1, 0, 8'd0);
    step("post_idle", 3'b000, 32'h0, 32'h0, 32'h0,
         32'h9, 3'b000, 0, 0, 8'd0);
`endif

    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alias_group_resolver.md
Name: alias_group_resolver

Overview:
- Resolves one shared WIDTH-bit net that N_CH channels may drive; it is the clocked, parametrised generalisation of a fixed three-way alias group with a single driver.
- Arbitrates ownership among simultaneous drivers, registers the resolved value, and flags and counts driver conflicts.
- Sits between per-channel driver logic and any consumer that needs one coherent net value; every channel reads back the same net_q.

Parameters:
- WIDTH, 32, bit width of the shared net and of each driver.
- N_CH, 3, number of channels that may drive the net (min 2).
- RESET_VAL, 0 (WIDTH bits), value of net_q after reset.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- drv_en  input  N_CH  per-channel drive request, level-sensitive.
- drv_data  input  N_CH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- net_q  output  WIDTH  resolved, registered net value.
- owner_vld  output  1  a channel currently owns the net.
- owner_oh  output  N_CH  one-hot owner; all zero when owner_vld=0.
- conflict  output  1  one-cycle pulse on a driver disagreement.
- conflict_cnt  output  CNT_W  saturating count of conflict pulses.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - net_q=RESET_VAL, owner_vld=0, owner_oh=0, conflict=0, conflict_cnt=0.
  - Round-robin pointer rr_ptr=0 (channel 0 has highest priority first).
- FSM has two states, IDLE and OWNED; owner_vld=1 exactly in OWNED.
- IDLE, no drv_en bit set: stay IDLE; net_q holds its value.
- IDLE, any drv_en bit set:
  - Grant the first requester at or after rr_ptr, searching upward with wrap at N_CH-1 -> 0.
  - Next edge: OWNED, owner_oh=grant, net_q=that channel's data.
  - Latency is 1 cycle from request to net_q.
- OWNED, owner's drv_en high:
  - Lock: keep the owner even if others request.
  - net_q tracks owner data each cycle with 1-cycle latency.
- OWNED, owner's drv_en low (release):
  - Set rr_ptr = owner+1 (mod N_CH).
  - If other requesters exist, hand off on the same edge to the next requester after the old owner; net_q takes the new owner's data. There is no IDLE bubble.
  - Otherwise go to IDLE; net_q holds the last owner value and owner_oh clears.
- Conflict detection:
  - Evaluated every cycle and independent of ownership.
  - Condition: two or more drv_en bits high and at least one enabled driver's data differs from another's.
  - Response: conflict=1 on the next cycle only.
  - Equal data from multiple drivers is not a conflict. Ownership still applies in that case.
- conflict_cnt increments on each conflict pulse and saturates at all-ones; it clears only on reset.
- Reset mid-operation immediately forces all reset values; any in-flight grant is discarded.
- Ownership and conflict logic reference no X/Z. Undriven state is represented only by IDLE plus the held net_q.

Optional Feature:
- Macro: ALIAS_RESOLVER_WAND_EN.
- Defined (wired-AND resolution):
  - No arbitration; the FSM is unused.
  - net_q <= bitwise AND of drv_data over all enabled channels; it holds when none are enabled.
  - owner_oh <= drv_en registered; owner_vld <= |drv_en registered.
  - conflict and conflict_cnt behave as above.
- Undefined: round-robin ownership as in Behaviour.

Test Plan (N_CH=3, WIDTH=32):
- Reset then idle 5 cycles -> net_q=0, owner_vld=0, conflict_cnt=0.
- drv_en=3'b001, ch0=32'hdeadbeef for 1 cycle then held -> next cycle net_q=deadbeef, owner_oh=001. Drop drv_en -> IDLE, net_q stays deadbeef.
- Owner ch0 held; drv_en=3'b111, all data=32'hdeadbeef -> owner stays ch0, conflict stays 0.
- drv_en=3'b110, ch1=32'h1, ch2=32'h2 from IDLE with rr_ptr=1 -> ch1 owns, net_q=1, conflict pulses once, conflict_cnt=1.
- Then ch1 releases while ch2 still requests -> same edge owner_oh=100, net_q=2, no IDLE cycle.
- Force disagreeing drivers for 300 cycles with CNT_W=8 -> conflict_cnt saturates at 255.
- Assert rst_n low mid-ownership -> all outputs return to reset values asynchronously.
- With ALIAS_RESOLVER_WAND_EN: drv_en=3'b011, ch0=32'hf0f0ffff, ch1=32'hffff0f0f -> net_q=f0f00f0f, owner_oh=011, conflict=1.
